pit_ctrl: RTL and testbench

- Controller that sits between the CPU I/O bus and the PIT.
- Generates the 1.193182 MHz clock-enable for the PIT from the system clock using a fractional accumulator.
- After reset, and on request, runs a fixed write sequence that programs PIT channels 0 and 2.
- Shares the PIT write/read port between that sequencer and CPU I/O cycles; CPU cycles that arrive during init are buffered and replayed.

---
 rtl/pit_ctrl_pkg.sv | 36 +++
 rtl/pit_ctrl_clken_gen.sv | 39 +++
 rtl/pit_ctrl.sv | 177 +++++++++++++++++
 tb/tb_pit_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pit_ctrl_pkg.sv
// Shared constants, state encoding and the init write table for pit_ctrl.
package pit_ctrl_pkg;

    localparam logic [11:0] PIT_ADDR_CH0  = 12'h040;
    localparam logic [11:0] PIT_ADDR_CH1  = 12'h041;
    localparam logic [11:0] PIT_ADDR_CH2  = 12'h042;
    localparam logic [11:0] PIT_ADDR_CTRL = 12'h043;

    // Control words: channel select, LSB-then-MSB access, mode 3 (square wave)
    localparam logic [7:0] CW_CH0_MODE3 = 8'h36;
    localparam logic [7:0] CW_CH2_MODE3 = 8'hB6;

    localparam int INIT_LEN = 6;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_GAP,
        ST_RUN
    } state_e;

    // Init table entry k as {address, data}; channel 0 gets count 0 (65536)
    function automatic logic [19:0] init_entry(input logic [2:0] k, input logic [15:0] ch2_count);
        logic [19:0] e;
        case (k)
            3'd0:    e = {PIT_ADDR_CTRL, CW_CH0_MODE3};
            3'd1:    e = {PIT_ADDR_CH0, 8'h00};
            3'd2:    e = {PIT_ADDR_CH0, 8'h00};
            3'd3:    e = {PIT_ADDR_CTRL, CW_CH2_MODE3};
            3'd4:    e = {PIT_ADDR_CH2, ch2_count[7:0]};
            3'd5:    e = {PIT_ADDR_CH2, ch2_count[15:8]};
            default: e = 20'h0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/pit_ctrl_clken_gen.sv
// Fractional accumulator producing a one-cycle enable at an average rate of PIT_HZ.
module pit_clken_gen #(
    parameter int unsigned CLK_HZ = 25000000,
    parameter int unsigned PIT_HZ = 1193182
) (
    input  logic iClk,
    input  logic iRst,
    output logic oClkEn
);

    logic [31:0] acc_q, acc_d;
    logic        en_q, en_d;
    logic [32:0] sum;

    // Add PIT_HZ each cycle; wrap by CLK_HZ and pulse on wrap (33-bit sum avoids overflow)
    always_comb begin
        sum  = {1'b0, acc_q} + 33'(PIT_HZ);
        acc_d = sum[31:0];
        en_d  = 1'b0;
        if (sum >= 33'(CLK_HZ)) begin
            acc_d = 32'(sum - 33'(CLK_HZ));
            en_d  = 1'b1;
        end
    end

    // Accumulator and pulse registers
    always_ff @(posedge iClk) begin
        if (iRst) begin
            acc_q <= 32'h0;
            en_q  <= 1'b0;
        end else begin
            acc_q <= acc_d;
            en_q  <= en_d;
        end
    end

    assign oClkEn = en_q;

endmodule

// File: rtl/pit_ctrl.sv
// PIT front-end: clock-enable generation, power-on programming sequence and
// arbitration of the PIT port between the sequencer and CPU I/O cycles.
// All PIT-side outputs are registered, so every strobe appears one cycle after
// the state/CPU cycle that produced it.
module pit_ctrl
    import pit_ctrl_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 25000000,
    parameter int unsigned PIT_HZ    = 1193182,
    parameter logic [15:0] CH2_COUNT = 16'h04A9
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iReinit,
    input  logic [11:0] iCpuAddr,
    input  logic [7:0]  iCpuData,
    input  logic        iCpuWr,
    input  logic        iCpuRd,
    output logic        oPitClkEn,
    output logic [11:0] oPitAddr,
    output logic [7:0]  oPitData,
    output logic        oPitWr,
    output logic        oPitRd,
    output logic        oBusy,
    output logic        oCpuWait,
    output logic        oOverrun
);

    localparam logic [2:0] LAST_STEP = 3'(INIT_LEN - 1);

    state_e      state_q, state_d;
    logic [2:0]  step_q, step_d;
    logic        pend_vld_q, pend_vld_d;
    logic        pend_wr_q, pend_wr_d;
    logic [11:0] pend_addr_q, pend_addr_d;
    logic [7:0]  pend_data_q, pend_data_d;
    logic [11:0] pit_addr_q, pit_addr_d;
    logic [7:0]  pit_data_q, pit_data_d;
    logic        pit_wr_q, pit_wr_d;
    logic        pit_rd_q, pit_rd_d;
    logic        busy_q, busy_d;
    logic        ovr_q, ovr_d;

    logic        cpu_req;
    logic        in_range;
    logic        capture;
    logic        slot_free;
    logic [19:0] entry;

    pit_clken_gen #(
        .CLK_HZ(CLK_HZ),
        .PIT_HZ(PIT_HZ)
    ) u_clken (
        .iClk  (iClk),
        .iRst  (iRst),
        .oClkEn(oPitClkEn)
    );

    assign cpu_req  = iCpuWr | iCpuRd;
    assign in_range = (iCpuAddr >= PIT_ADDR_CH0) && (iCpuAddr <= PIT_ADDR_CTRL);
    // While the sequencer owns the port, only PIT-range CPU cycles are buffered
    assign capture  = (state_q != ST_RUN) && cpu_req && in_range;

    // Next state, PIT strobes and pending-buffer update
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        pend_vld_d  = pend_vld_q;
        pend_wr_d   = pend_wr_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        pit_addr_d  = 12'h0;
        pit_data_d  = 8'h0;
        pit_wr_d    = 1'b0;
        pit_rd_d    = 1'b0;
        ovr_d       = 1'b0;
        slot_free   = 1'b0;
        busy_d      = (state_q != ST_RUN);
        entry       = init_entry(step_q, CH2_COUNT);

        case (state_q)
            ST_INIT: begin
                pit_wr_d   = 1'b1;
                pit_addr_d = entry[19:8];
                pit_data_d = entry[7:0];
                state_d    = ST_GAP;
            end
            ST_GAP: begin
                if (pend_vld_q) begin
                    pit_wr_d   = pend_wr_q;
                    pit_rd_d   = ~pend_wr_q;
                    pit_addr_d = pend_addr_q;
                    pit_data_d = pend_data_q;
                    slot_free  = 1'b1;
                end
                if (step_q == LAST_STEP) begin
                    // A capture here refills the buffer; spend another GAP draining it
                    state_d = capture ? ST_GAP : ST_RUN;
                end else begin
                    step_d  = step_q + 3'd1;
                    state_d = ST_INIT;
                end
            end
            ST_RUN: begin
                // Write wins if both strobes arrive, so the PIT never sees both
                pit_wr_d = iCpuWr;
                pit_rd_d = iCpuRd & ~iCpuWr;
                if (cpu_req) begin
                    pit_addr_d = iCpuAddr;
                    pit_data_d = iCpuData;
                end
            end
            default: begin
                state_d = ST_INIT;
                step_d  = 3'd0;
            end
        endcase

        if (capture) begin
            if (!pend_vld_q || slot_free) begin
                pend_vld_d  = 1'b1;
                pend_wr_d   = iCpuWr;
                pend_addr_d = iCpuAddr;
                pend_data_d = iCpuData;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (slot_free) begin
            pend_vld_d = 1'b0;
        end

        if (iReinit) begin
            state_d = ST_INIT;
            step_d  = 3'd0;
        end
    end

    // State, buffer and registered outputs
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q     <= ST_INIT;
            step_q      <= 3'd0;
            pend_vld_q  <= 1'b0;
            pend_wr_q   <= 1'b0;
            pend_addr_q <= 12'h0;
            pend_data_q <= 8'h0;
            pit_addr_q  <= 12'h0;
            pit_data_q  <= 8'h0;
            pit_wr_q    <= 1'b0;
            pit_rd_q    <= 1'b0;
            busy_q      <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            pend_vld_q  <= pend_vld_d;
            pend_wr_q   <= pend_wr_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            pit_addr_q  <= pit_addr_d;
            pit_data_q  <= pit_data_d;
            pit_wr_q    <= pit_wr_d;
            pit_rd_q    <= pit_rd_d;
            busy_q      <= busy_d;
            ovr_q       <= ovr_d;
        end
    end

    assign oPitAddr = pit_addr_q;
    assign oPitData = pit_data_q;
    assign oPitWr   = pit_wr_q;
    assign oPitRd   = pit_rd_q;
    assign oBusy    = busy_q;
    assign oCpuWait = pend_vld_q;
    assign oOverrun = ovr_q;

endmodule

// File: tb/tb_pit_ctrl.sv
// Self-checking bench for pit_ctrl. Inputs are driven and outputs sampled on the
// falling edge; PIT strobes are checked against a queue of expected
// {cycle, wr, rd, addr, data} words filled when the stimulus is chosen.
module tb_pit_ctrl;

  localparam int unsigned CLK_HZ = 25000000;
  localparam int unsigned PIT_HZ = 1193182;

  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic        iReinit = 1'b0;
  logic [11:0] iCpuAddr = 12'h0;
  logic [7:0]  iCpuData = 8'h0;
  logic        iCpuWr = 1'b0;
  logic        iCpuRd = 1'b0;
  logic        oPitClkEn;
  logic [11:0] oPitAddr;
  logic [7:0]  oPitData;
  logic        oPitWr;
  logic        oPitRd;
  logic        oBusy;
  logic        oCpuWait;
  logic        oOverrun;

  int n_cmp = 0;
  int n_err = 0;
  logic [37:0] exp_q[$];
  logic [37:0] obs;
  logic [37:0] exp_w;

  logic [11:0] tbl_addr[6] = '{12'h043, 12'h040, 12'h040, 12'h043, 12'h042, 12'h042};
  logic [7:0]  tbl_data[6] = '{8'h36, 8'h00, 8'h00, 8'hB6, 8'hA9, 8'h04};

  pit_ctrl #(
    .CLK_HZ(CLK_HZ),
    .PIT_HZ(PIT_HZ),
    .CH2_COUNT(16'h04A9)
  ) dut (
    .iClk(iClk), .iRst(iRst), .iReinit(iReinit),
    .iCpuAddr(iCpuAddr), .iCpuData(iCpuData), .iCpuWr(iCpuWr), .iCpuRd(iCpuRd),
    .oPitClkEn(oPitClkEn), .oPitAddr(oPitAddr), .oPitData(oPitData),
    .oPitWr(oPitWr), .oPitRd(oPitRd), .oBusy(oBusy), .oCpuWait(oCpuWait),
    .oOverrun(oOverrun)
  );

  // clock / reset
  always #5 iClk = ~iClk;

  task automatic idle_inputs();
    iReinit = 1'b0;
    iCpuWr = 1'b0;
    iCpuRd = 1'b0;
    iCpuAddr = 12'h0;
    iCpuData = 8'h0;
  endtask

  // One reset cycle; returns in cycle 0 (first cycle with iRst low)
  task automatic do_reset();
    @(negedge iClk);
    idle_inputs();
    iRst = 1'b1;
    @(negedge iClk);
    iRst = 1'b0;
    exp_q.delete();
  endtask

  // Expect the first n table writes on cycles base+1, base+3, ...
  task automatic push_table(input int base, input int n);
    for (int k = 0; k < n; k++)
      exp_q.push_back({16'(base + 2 * k + 1), 1'b1, 1'b0, tbl_addr[k], tbl_data[k]});
  endtask

  task automatic cpu_op(input logic wr, input logic rd, input logic [11:0] a, input logic [7:0] d);
    iCpuWr = wr;
    iCpuRd = rd;
    iCpuAddr = a;
    iCpuData = d;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (oPitWr !== 1'b0) begin n_err++; $display("FAIL reset_wr: got %b want 0", oPitWr); end
    n_cmp++; if (oPitRd !== 1'b0) begin n_err++; $display("FAIL reset_rd: got %b want 0", oPitRd); end
    n_cmp++; if (oPitAddr !== 12'h0) begin n_err++; $display("FAIL reset_addr: got %h want 000", oPitAddr); end
    n_cmp++; if (oPitData !== 8'h0) begin n_err++; $display("FAIL reset_data: got %h want 00", oPitData); end
    n_cmp++; if (oBusy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", oBusy); end
    n_cmp++; if (oCpuWait !== 1'b0) begin n_err++; $display("FAIL reset_wait: got %b want 0", oCpuWait); end
    n_cmp++; if (oOverrun !== 1'b0) begin n_err++; $display("FAIL reset_ovr: got %b want 0", oOverrun); end
    n_cmp++; if (oPitClkEn !== 1'b0) begin n_err++; $display("FAIL reset_clken: got %b want 0", oPitClkEn); end
  endtask

  // Continues from test_reset's cycle 0
  task automatic test_init_seq();
    logic exp_busy;
    push_table(0, 6);
    for (int c = 1; c <= 14; c++) begin
      @(negedge iClk);
      obs = {16'(c), oPitWr, oPitRd, oPitAddr, oPitData};
      if (oPitWr || oPitRd) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL init_strobe: got %h want none", obs); end
        else begin
          exp_w = exp_q.pop_front();
          if (obs !== exp_w) begin n_err++; $display("FAIL init_strobe: got %h want %h", obs, exp_w); end
        end
      end
      exp_busy = (c >= 1) && (c <= 12);
      n_cmp++; if (oBusy !== exp_busy) begin n_err++; $display("FAIL init_busy c=%0d: got %b want %b", c, oBusy, exp_busy); end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL init_missing: got %0d left want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_clken();
    int pulses;
    int adj;
    logic prev;
    logic exp_en;
    longint unsigned cl;
    pulses = 0;
    adj = 0;
    prev = 1'b0;
    do_reset();
    for (int c = 1; c <= 1000; c++) begin
      @(negedge iClk);
      cl = longint'(c);
      exp_en = ((cl * PIT_HZ) / CLK_HZ) != (((cl - 1) * PIT_HZ) / CLK_HZ);
      if (oPitClkEn !== exp_en) begin
        n_cmp++; n_err++;
        $display("FAIL clken c=%0d: got %b want %b", c, oPitClkEn, exp_en);
      end
      if (oPitClkEn === 1'b1) pulses++;
      if (oPitClkEn === 1'b1 && prev) adj++;
      prev = oPitClkEn;
    end
    n_cmp++; if (pulses != 47) begin n_err++; $display("FAIL clken_count: got %0d want 47", pulses); end
    n_cmp++; if (adj != 0) begin n_err++; $display("FAIL clken_adjacent: got %0d want 0", adj); end
    exp_q.delete();
  endtask

  // Runs in RUN state: fixed write, then random traffic, all with 1-cycle latency
  task automatic test_run_fwd();
    int op;
    logic [11:0] a;
    logic [7:0] d;
    exp_q.delete();
    for (int c = 0; c < 30; c++) begin
      @(negedge iClk);
      obs = {16'(c), oPitWr, oPitRd, oPitAddr, oPitData};
      if (oPitWr || oPitRd) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL run_strobe: got %h want none", obs); end
        else begin
          exp_w = exp_q.pop_front();
          if (obs !== exp_w) begin n_err++; $display("FAIL run_strobe: got %h want %h", obs, exp_w); end
        end
      end
      n_cmp++; if (oBusy !== 1'b0 || oCpuWait !== 1'b0) begin n_err++; $display("FAIL run_flags c=%0d: got %b%b want 00", c, oBusy, oCpuWait); end
      idle_inputs();
      if (c == 0) begin
        cpu_op(1'b1, 1'b0, 12'h042, 8'h55);
        exp_q.push_back({16'(c + 1), 1'b1, 1'b0, 12'h042, 8'h55});
      end else if (c >= 3 && c < 26) begin
        op = int'($urandom_range(0, 3));
        a = 12'h040 + 12'($urandom_range(0, 3));
        d = 8'($urandom_range(0, 255));
        if (op == 1 || op == 2) begin
          cpu_op(op == 1, op == 2, a, d);
          exp_q.push_back({16'(c + 1), op == 1, op == 2, a, d});
        end
      end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL run_missing: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_cpu_during_init();
    logic exp_wait;
    logic exp_ovr;
    do_reset();
    push_table(0, 6);
    // replay of the buffered 0x043 write comes out after GAP step 1
    exp_q.insert(2, {16'd4, 1'b1, 1'b0, 12'h043, 8'h80});
    cpu_op(1'b1, 1'b0, 12'h061, 8'hEE);
    for (int c = 1; c <= 14; c++) begin
      @(negedge iClk);
      obs = {16'(c), oPitWr, oPitRd, oPitAddr, oPitData};
      if (oPitWr || oPitRd) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL buf_strobe: got %h want none", obs); end
        else begin
          exp_w = exp_q.pop_front();
          if (obs !== exp_w) begin n_err++; $display("FAIL buf_strobe: got %h want %h", obs, exp_w); end
        end
      end
      exp_wait = (c == 2) || (c == 3);
      exp_ovr = (c == 3);
      n_cmp++; if (oCpuWait !== exp_wait) begin n_err++; $display("FAIL buf_wait c=%0d: got %b want %b", c, oCpuWait, exp_wait); end
      n_cmp++; if (oOverrun !== exp_ovr) begin n_err++; $display("FAIL buf_ovr c=%0d: got %b want %b", c, oOverrun, exp_ovr); end
      idle_inputs();
      if (c == 1) cpu_op(1'b1, 1'b0, 12'h043, 8'h80);
      if (c == 2) cpu_op(1'b1, 1'b0, 12'h042, 8'h11);
    end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL buf_missing: got %0d left want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_reset_midseq();
    logic exp_busy;
    do_reset();
    push_table(0, 3);
    push_table(7, 6);
    for (int c = 1; c <= 22; c++) begin
      @(negedge iClk);
      obs = {16'(c), oPitWr, oPitRd, oPitAddr, oPitData};
      if (oPitWr || oPitRd) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL rst_strobe: got %h want none", obs); end
        else begin
          exp_w = exp_q.pop_front();
          if (obs !== exp_w) begin n_err++; $display("FAIL rst_strobe: got %h want %h", obs, exp_w); end
        end
      end
      exp_busy = ((c >= 1) && (c <= 6)) || ((c >= 8) && (c <= 19));
      n_cmp++; if (oBusy !== exp_busy) begin n_err++; $display("FAIL rst_busy c=%0d: got %b want %b", c, oBusy, exp_busy); end
      n_cmp++; if (oCpuWait !== (c == 6)) begin n_err++; $display("FAIL rst_wait c=%0d: got %b want %b", c, oCpuWait, c == 6); end
      idle_inputs();
      if (c == 5) cpu_op(1'b0, 1'b1, 12'h040, 8'h00);
      iRst = (c == 6);
    end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rst_missing: got %0d left want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  // Starts in RUN; reinit pulse together with a CPU write
  task automatic test_reinit();
    logic exp_busy;
    exp_q.delete();
    exp_q.push_back({16'd1, 1'b1, 1'b0, 12'h042, 8'h77});
    push_table(1, 6);
    for (int c = 0; c <= 16; c++) begin
      @(negedge iClk);
      obs = {16'(c), oPitWr, oPitRd, oPitAddr, oPitData};
      if (oPitWr || oPitRd) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL reinit_strobe: got %h want none", obs); end
        else begin
          exp_w = exp_q.pop_front();
          if (obs !== exp_w) begin n_err++; $display("FAIL reinit_strobe: got %h want %h", obs, exp_w); end
        end
      end
      exp_busy = (c >= 2) && (c <= 13);
      n_cmp++; if (oBusy !== exp_busy) begin n_err++; $display("FAIL reinit_busy c=%0d: got %b want %b", c, oBusy, exp_busy); end
      idle_inputs();
      if (c == 0) begin
        iReinit = 1'b1;
        cpu_op(1'b1, 1'b0, 12'h042, 8'h77);
      end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL reinit_missing: got %0d left want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_init_seq();
    test_clken();
    test_run_fwd();
    test_cpu_during_init();
    test_reset_midseq();
    test_reinit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
